multicycle_ctrl: RTL and testbench

Multicycle main controller for the RV32I subset core. It sequences fetch, decode, execute, memory and writeback over a shared single-port memory. It decodes the latched instruction and drives the datapath enables, including ext_op into the immediate-extension unit.

---
 rtl/multicycle_ctrl_pkg.sv | 20 ++
 rtl/multicycle_ctrl_decode.sv | 30 +++
 rtl/multicycle_ctrl.sv | 97 +++++++++
 tb/tb_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state, opcode, immediate-type and writeback encodings shared by the controller and extension unit
package multicycle_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [1:0] EXT_NONE = 2'b00;
  localparam logic [1:0] EXT_I    = 2'b01;
  localparam logic [1:0] EXT_S    = 2'b10;
  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// mctrl_decode: combinational opcode/funct decode into datapath controls and instruction class flags
module mctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  ext_op,
  output logic        alu_src,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  wd_sel,
  output logic        is_load,
  output logic        is_store,
  output logic        legal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic is_r, is_i, unused_bits;
  assign op          = instr[6:0];
  assign f3          = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign is_r        = op == OP_R;
  assign is_i        = op == OP_I;
  assign is_load     = op == OP_LOAD;
  assign is_store    = op == OP_STORE;
  assign legal       = is_r | is_i | is_load | is_store;
  assign ext_op      = is_store ? EXT_S : (is_i | is_load) ? EXT_I : EXT_NONE;
  assign alu_src     = is_i | is_load | is_store;
  // instr[30] selects sub/sra; for I-type it is only an opcode bit on shift-right
  assign alu_ctrl    = is_r ? {instr[30], f3} : is_i ? {instr[30] && f3 == 3'b101, f3} : 4'b0000;
  assign wd_sel      = is_load ? WD_MEM : WD_ALU;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I-subset multicycle FSM controller with memory watchdog; MCTRL_PERF_EN adds perf counters
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int WCNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_isel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  ext_op,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired
`endif
);
  localparam logic [WCNT_W-1:0] LIM_M1 = WCNT_W'(WAIT_LIMIT - 1);
  state_t cur, nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [1:0] d_ext, d_wd;
  logic [3:0] d_alu;
  logic d_src, legal, is_load, is_store, waiting, expire, ex_phase;
  mctrl_decode u_dec (
    .instr   (instr),
    .ext_op  (d_ext),
    .alu_src (d_src),
    .alu_ctrl(d_alu),
    .wd_sel  (d_wd),
    .is_load (is_load),
    .is_store(is_store),
    .legal   (legal)
  );
  assign waiting = (cur == S_IF || cur == S_MEM) && !mem_ready;
  // the limit cycle counts as a wait only if mem_ready is still low in it
  assign expire  = WAIT_LIMIT != 0 && waiting && wcnt == LIM_M1;
  always_comb begin
    nxt = cur;
    case (cur)
      S_IF:    nxt = mem_ready ? S_ID : expire ? S_TRAP : S_IF;
      S_ID:    nxt = legal ? S_EX : S_TRAP;
      S_EX:    nxt = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM:   nxt = mem_ready ? (is_store ? S_IF : S_WB) : expire ? S_TRAP : S_MEM;
      S_WB:    nxt = S_IF;
      default: nxt = S_TRAP;
    endcase
    ex_phase = cur == S_EX || cur == S_MEM || cur == S_WB;
    mem_req  = rst_n && (cur == S_IF || cur == S_MEM);
    mem_isel = cur == S_IF;
    mem_we   = cur == S_MEM && is_store;
    ir_we    = rst_n && cur == S_IF && mem_ready;
    pc_we    = ir_we;
    rf_we    = cur == S_WB;
    wd_sel   = cur == S_WB ? d_wd : WD_ALU;
    alu_src  = ex_phase && d_src;
    alu_ctrl = ex_phase ? d_alu : 4'b0000;
    ext_op   = ex_phase ? d_ext : EXT_NONE;
    state    = cur;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur     <= S_IF;
      wcnt    <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cur     <= nxt;
      wcnt    <= (waiting && nxt == cur) ? wcnt + 1'b1 : '0;
      illegal <= illegal | (cur == S_ID && !legal);
      timeout <= timeout | expire;
    end
  end
`ifdef MCTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      if (cur != S_TRAP) perf_cycles <= perf_cycles + 32'd1;
      if (cur == S_WB || (cur == S_MEM && is_store && mem_ready)) perf_retired <= perf_retired + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl with a 4-cycle watchdog
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = '0;
  logic mem_req, mem_we, mem_isel, ir_we, pc_we, rf_we, alu_src, illegal, timeout;
  logic [1:0] wd_sel, ext_op;
  logic [3:0] alu_ctrl;
  logic [2:0] state;
`ifdef MCTRL_PERF_EN
  logic [31:0] perf_cycles, perf_retired;
`endif
  int n_checks = 0, n_fail = 0;
  multicycle_ctrl #(.WAIT_LIMIT(4), .WCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_isel(mem_isel), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .wd_sel(wd_sel), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .ext_op(ext_op), .illegal(illegal), .timeout(timeout),
    .state(state)
`ifdef MCTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r);
    @(posedge clk);
    #1 mem_ready = r;
    #1;
  endtask
  initial begin
    step(0);
    step(1);
    chk("rst_state", 32'(state), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_we", 32'(ir_we), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_timeout", 32'(timeout), 0);
    // addi x1,x0,5
    rst_n = 1'b1;
    instr = 32'h00500093;
    #1;
    chk("addi_if_req", 32'(mem_req), 1);
    chk("addi_if_isel", 32'(mem_isel), 1);
    chk("addi_if_we", 32'(mem_we), 0);
    chk("addi_if_ir_we", 32'(ir_we), 1);
    chk("addi_if_pc_we", 32'(pc_we), 1);
    step(1);
    chk("addi_id", 32'(state), 1);
    chk("addi_id_req", 32'(mem_req), 0);
    chk("addi_id_ir_we", 32'(ir_we), 0);
    step(1);
    chk("addi_ex", 32'(state), 2);
    chk("addi_ex_ext", 32'(ext_op), 1);
    chk("addi_ex_src", 32'(alu_src), 1);
    chk("addi_ex_alu", 32'(alu_ctrl), 0);
    chk("addi_ex_rf_we", 32'(rf_we), 0);
    step(1);
    chk("addi_wb", 32'(state), 4);
    chk("addi_wb_rf_we", 32'(rf_we), 1);
    chk("addi_wb_wd", 32'(wd_sel), 0);
    chk("addi_wb_ext", 32'(ext_op), 1);
    step(1);
    chk("addi_done", 32'(state), 0);
    chk("addi_done_rf_we", 32'(rf_we), 0);
    // lw x2,4(x1) with three wait cycles in MEM
    instr = 32'h0040A103;
    step(1);
    chk("lw_id", 32'(state), 1);
    step(0);
    chk("lw_ex", 32'(state), 2);
    chk("lw_ex_ext", 32'(ext_op), 1);
    chk("lw_ex_alu", 32'(alu_ctrl), 0);
    chk("lw_ex_src", 32'(alu_src), 1);
    step(0);
    chk("lw_mem1", 32'(state), 3);
    chk("lw_mem1_req", 32'(mem_req), 1);
    chk("lw_mem1_isel", 32'(mem_isel), 0);
    chk("lw_mem1_we", 32'(mem_we), 0);
    step(0);
    chk("lw_mem2", 32'(state), 3);
    step(0);
    chk("lw_mem3", 32'(state), 3);
    step(1);
    chk("lw_mem4", 32'(state), 3);
    chk("lw_mem4_req", 32'(mem_req), 1);
    step(1);
    chk("lw_wb", 32'(state), 4);
    chk("lw_wb_wd", 32'(wd_sel), 1);
    chk("lw_wb_rf_we", 32'(rf_we), 1);
    chk("lw_timeout", 32'(timeout), 0);
    step(1);
    chk("lw_done", 32'(state), 0);
    // sw x2,8(x1)
    instr = 32'h0020A423;
    step(1);
    step(1);
    chk("sw_ex", 32'(state), 2);
    chk("sw_ex_ext", 32'(ext_op), 2);
    chk("sw_ex_src", 32'(alu_src), 1);
    chk("sw_ex_alu", 32'(alu_ctrl), 0);
    step(1);
    chk("sw_mem", 32'(state), 3);
    chk("sw_mem_we", 32'(mem_we), 1);
    chk("sw_mem_req", 32'(mem_req), 1);
    chk("sw_mem_rf_we", 32'(rf_we), 0);
    step(1);
    chk("sw_done", 32'(state), 0);
    chk("sw_done_rf_we", 32'(rf_we), 0);
    // sub x3,x1,x2
    instr = 32'h402081B3;
    step(1);
    step(1);
    chk("sub_alu", 32'(alu_ctrl), 8);
    chk("sub_src", 32'(alu_src), 0);
    chk("sub_ext", 32'(ext_op), 0);
    step(1);
    chk("sub_wb_alu", 32'(alu_ctrl), 8);
    step(1);
    // add x3,x1,x2
    instr = 32'h002081B3;
    step(1);
    step(1);
    chk("add_alu", 32'(alu_ctrl), 0);
    chk("add_src", 32'(alu_src), 0);
    step(1);
    step(1);
    // srai x1,x1,3
    instr = 32'h4030D093;
    step(1);
    step(1);
    chk("srai_alu", 32'(alu_ctrl), 4'hD);
    chk("srai_src", 32'(alu_src), 1);
    step(1);
    step(1);
    // addi x1,x0,0x400: instr[30] set but funct3 is not 101
    instr = 32'h40000093;
    step(1);
    step(1);
    chk("addi_b30_alu", 32'(alu_ctrl), 0);
    step(1);
    step(1);
    chk("alu_seq_done", 32'(state), 0);
    // illegal opcode
    instr = 32'hFFFFFFFF;
    step(1);
    chk("ill_id", 32'(state), 1);
    step(1);
    chk("ill_trap", 32'(state), 7);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_req", 32'(mem_req), 0);
    step(1);
    chk("ill_sticky_state", 32'(state), 7);
    chk("ill_sticky_flag", 32'(illegal), 1);
    chk("ill_sticky_req", 32'(mem_req), 0);
    chk("ill_ir_we", 32'(ir_we), 0);
    rst_n = 1'b0;
    step(1);
    chk("ill_rst_state", 32'(state), 0);
    chk("ill_rst_flag", 32'(illegal), 0);
    chk("ill_rst_req", 32'(mem_req), 0);
    // watchdog expiry in IF
    instr = 32'h00500093;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("wd_w1_req", 32'(mem_req), 1);
    step(0);
    step(0);
    step(0);
    chk("wd_w4_state", 32'(state), 0);
    chk("wd_w4_timeout", 32'(timeout), 0);
    chk("wd_w4_req", 32'(mem_req), 1);
    step(0);
    chk("wd_trap", 32'(state), 7);
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_req", 32'(mem_req), 0);
    chk("wd_illegal", 32'(illegal), 0);
    rst_n = 1'b0;
    step(0);
    chk("wd_rst_timeout", 32'(timeout), 0);
    // mem_ready arriving in the limit cycle wins
    rst_n = 1'b1;
    step(0);
    step(0);
    step(1);
    chk("wd_edge_state", 32'(state), 0);
    chk("wd_edge_ir_we", 32'(ir_we), 1);
    step(1);
    chk("wd_edge_id", 32'(state), 1);
    chk("wd_edge_timeout", 32'(timeout), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
